// File: rtl/bcd_pkg.sv
// Shared types and constant helpers for the serial binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD nibble that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) d_o = d_i + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Serial double-dabble binary-to-BCD converter, one adjust/shift step per clock,
// with valid/ready handshakes, overflow saturation and leading-zero mask.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 12,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic [DIGITS-1:0]     out_lz
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned SR_W   = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = clog2(BIN_W + 1);
  localparam logic [63:0] OVF_TH = pow10(DIGITS);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 ovf_out_q, ovf_out_d;
  logic [DIGITS-1:0]    lz_q, lz_d;

  logic [BCD_W-1:0]     adj_bcd;
  logic [SR_W-1:0]      sr_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (sr_q[BIN_W + 4*g +: 4]),
      .d_o (adj_bcd[4*g +: 4])
    );
  end

  // Corrected BCD field rejoined with the remaining binary bits, then shifted.
  assign sr_shift = {adj_bcd, sr_q[BIN_W-1:0]} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
      lz_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      ovf_out_q <= ovf_out_d;
      lz_q      <= lz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    ovf_out_d = ovf_out_q;
    lz_d      = lz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d  = {{BCD_W{1'b0}}, bin_in};
          cnt_d = CNT_W'(BIN_W);
          ovf_d = (64'(bin_in) >= OVF_TH);
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d     = ovf_q ? {DIGITS{4'h9}} : sr_shift[SR_W-1:BIN_W];
          ovf_out_d = ovf_q;
          lz_d[0]   = 1'b0;
          // Digit i is blankable when it and every digit above it are zero.
          for (int unsigned i = 1; i < DIGITS; i++) begin
            lz_d[i] = ((bcd_d >> (4*i)) == '0);
          end
        end
      end
      default: ;
    endcase
  end

  assign out_bcd = bcd_q;
  assign out_ovf = ovf_out_q;
  assign out_lz  = lz_q;

endmodule
